pcpi_systolic_mmul: RTL and testbench

// - PicoRV32 PCPI coprocessor: N x N signed systolic matrix multiply-accumulate, C = A*B + BIAS.
// - Produces a binarised output mask (C[i][j] >= THRESH) and per-element readback of C.
// - Attaches to the core's PCPI bus and responds only to custom-0 opcode 7'b0001011.
// - Operands are loaded element-wise over rs1/rs2. Unknown funct3 gets no response, so the core traps.

---
 rtl/pcpi_mmul_pkg.sv | 24 ++
 rtl/pcpi_mmul_pe.sv | 41 ++++
 rtl/pcpi_systolic_mmul.sv | 215 +++++++++++++++++++++
 tb/tb_pcpi_systolic_mmul.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_mmul_pkg.sv
// Shared opcodes, register map bases and FSM state type
// for the PCPI systolic matrix multiply coprocessor.
package pcpi_mmul_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_WRITE = 3'b000;
  localparam logic [2:0] F3_READ  = 3'b010;
  localparam logic [2:0] F3_RUN   = 3'b111;
  localparam logic [2:0] F3_CLEAR = 3'b101;

  localparam logic [7:0] REG_A      = 8'h00;
  localparam logic [7:0] REG_B      = 8'h40;
  localparam logic [7:0] REG_BIAS   = 8'h80;
  localparam logic [7:0] REG_THRESH = 8'hC0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/pcpi_mmul_pe.sv
// Systolic processing element: signed MAC with bias seed
// and registered a (rightward) / b (downward) pass-through.
module pcpi_mmul_pe #(
  parameter int DW   = 16,
  parameter int ACCW = 35
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   seed,
  input  logic                   clr,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [DW-1:0]   b_in,
  input  logic signed [DW-1:0]   bias,
  output logic signed [DW-1:0]   a_out,
  output logic signed [DW-1:0]   b_out,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = a_in * b_in;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr)
        acc <= '0;
      else if (seed)
        acc <= ACCW'(bias) + ACCW'(prod);
      else if (en)
        acc <= acc + ACCW'(prod);
    end
  end

endmodule

// File: rtl/pcpi_systolic_mmul.sv
// PicoRV32 PCPI coprocessor: N x N signed systolic C = A*B + BIAS,
// thresholded mask on RUN and saturated per-element readback.
module pcpi_systolic_mmul
  import pcpi_mmul_pkg::*;
#(
  parameter int N    = 3,
  parameter int DW   = 16,
  parameter int ACCW = 2*DW+$clog2(N)+1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam int NN = N*N;
  localparam int CW = $clog2(3*N);
  localparam logic [CW-1:0] LAST = CW'(3*N-3);

  logic signed [DW-1:0]   a_m    [NN];
  logic signed [DW-1:0]   b_m    [NN];
  logic signed [DW-1:0]   bias_m [NN];
  logic signed [DW-1:0]   thresh;
  logic signed [DW-1:0]   wdata;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   done_latch;

  logic [2:0]             f3;
  logic [7:0]             idx;
  logic [5:0]             k_el;
  logic                   hi_zero;
  logic                   known;
  logic                   accept;
  logic                   go;
  logic                   run;
  logic                   clr;
  logic                   unused_bits;

  logic signed [DW-1:0]   a_feed [N];
  logic signed [DW-1:0]   b_feed [N];
  logic signed [DW-1:0]   a_in   [N][N];
  logic signed [DW-1:0]   b_in   [N][N];
  logic signed [DW-1:0]   a_pass [N][N];
  logic signed [DW-1:0]   b_pass [N][N];
  logic signed [ACCW-1:0] acc    [NN];

  logic signed [ACCW-1:0] rd_sel;
  logic signed [63:0]     rd_ext;
  logic [31:0]            rd_sat;
  logic [31:0]            mask;

  assign f3      = pcpi_insn[14:12];
  assign idx     = pcpi_rs1[7:0];
  assign k_el    = idx[5:0];
  assign hi_zero = (pcpi_rs1[31:8] == '0);
  assign wdata   = $signed(pcpi_rs2[DW-1:0]);
  assign known   = f3 inside {F3_WRITE, F3_READ, F3_RUN, F3_CLEAR};
  assign accept  = (state == S_IDLE) && pcpi_valid && !done_latch
                && (pcpi_insn[6:0] == OPC_CUSTOM0) && known;
  assign go      = accept && (f3 == F3_RUN);
  assign run     = (state == S_RUN);
  assign clr     = accept && (f3 == F3_CLEAR);

  assign unused_bits = ^{pcpi_insn[31:15], pcpi_insn[11:7],
                         pcpi_rs2[31:DW]};

  // Feed time 0 is the accept cycle itself (cnt idles at 0)
  always_comb begin
    int t;
    t = 0;
    for (int r = 0; r < N; r++) begin
      t = int'(cnt) - r;
      a_feed[r] = '0;
      b_feed[r] = '0;
      if ((go || run) && t >= 0 && t < N) begin
        a_feed[r] = a_m[r*N + t];
        b_feed[r] = b_m[t*N + r];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a0
        assign a_in[i][j] = a_feed[i];
      end else begin : g_an
        assign a_in[i][j] = a_pass[i][j-1];
      end
      if (i == 0) begin : g_b0
        assign b_in[i][j] = b_feed[j];
      end else begin : g_bn
        assign b_in[i][j] = b_pass[i-1][j];
      end
      pcpi_mmul_pe #(
        .DW   (DW),
        .ACCW (ACCW)
      ) u_pe (
        .clk    (clk),
        .resetn (resetn),
        .en     (run),
        .seed   (go),
        .clr    (clr),
        .a_in   (a_in[i][j]),
        .b_in   (b_in[i][j]),
        .bias   (bias_m[i*N+j]),
        .a_out  (a_pass[i][j]),
        .b_out  (b_pass[i][j]),
        .acc    (acc[i*N+j])
      );
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NN; k++)
      if (idx == 8'(k)) rd_sel = acc[k];
  end

  assign rd_ext = 64'(rd_sel);
  assign rd_sat =
    (rd_ext > 64'sh0000_0000_7fff_ffff) ? 32'h7fff_ffff :
    (rd_ext < 64'shffff_ffff_8000_0000) ? 32'h8000_0000 :
    rd_ext[31:0];

  always_comb begin
    mask = '0;
    for (int k = 0; k < NN; k++)
      mask[k] = (acc[k] >= ACCW'(thresh));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      done_latch <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      thresh     <= '0;
      for (int k = 0; k < NN; k++) begin
        a_m[k]    <= '0;
        b_m[k]    <= '0;
        bias_m[k] <= '0;
      end
    end else begin
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      if (!pcpi_valid) done_latch <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              (f3 == F3_RUN): begin
                state     <= S_RUN;
                cnt       <= CW'(1);
                pcpi_wait <= 1'b1;
              end
              (f3 == F3_READ): begin
                state      <= S_RESP;
                pcpi_ready <= 1'b1;
                pcpi_wr    <= 1'b1;
                pcpi_rd    <= rd_sat;
                done_latch <= 1'b1;
              end
              default: begin
                state      <= S_RESP;
                pcpi_ready <= 1'b1;
                done_latch <= 1'b1;
                if (f3 == F3_WRITE && hi_zero) begin
                  for (int k = 0; k < NN; k++) begin
                    if (k_el == 6'(k)) begin
                      if (idx[7:6] == REG_A[7:6])    a_m[k]    <= wdata;
                      if (idx[7:6] == REG_B[7:6])    b_m[k]    <= wdata;
                      if (idx[7:6] == REG_BIAS[7:6]) bias_m[k] <= wdata;
                    end
                  end
                  if (idx == REG_THRESH) thresh <= wdata;
                end
              end
            endcase
          end
        end
        S_RESP: state <= S_IDLE;
        S_RUN: begin
          if (cnt == LAST) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          pcpi_ready <= 1'b1;
          pcpi_wr    <= 1'b1;
          pcpi_rd    <= mask;
          pcpi_wait  <= 1'b0;
          done_latch <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_systolic_mmul.sv
// Scoreboard bench for pcpi_systolic_mmul (N=3): a plain
// matrix model predicts masks and readback values.
module tb_pcpi_systolic_mmul;
  import pcpi_mmul_pkg::*;

  localparam int N  = 3;
  localparam int NN = N*N;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  always #5 clk = ~clk;

  pcpi_systolic_mmul #(.N(N), .DW(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        wr;
    int          lat;
    int          waits;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint ma[NN], mb[NN], mbias[NN], mc[NN];
  longint mth;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    logic [63:0] u;
    u = v;
    if (v > 64'sd2147483647) return 32'h7fff_ffff;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return u[31:0];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NN; k++) begin
      ma[k] = 0; mb[k] = 0; mbias[k] = 0; mc[k] = 0;
    end
    mth = 0;
  endfunction

  function automatic void model_run();
    for (int k = 0; k < NN; k++) begin
      longint s;
      s = mbias[k];
      for (int m = 0; m < N; m++)
        s += ma[(k/N)*N+m] * mb[m*N+(k%N)];
      mc[k] = s;
    end
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < NN; k++) m[k] = (mc[k] >= mth);
    return m;
  endfunction

  task automatic op(input logic [2:0] f3, input logic [31:0] a1,
                    input logic [31:0] a2, input logic [31:0] erd,
                    input logic ewr, input int elat, input int hold,
                    input string tag);
    exp_t        e;
    int          n, waits, extra;
    logic        seen, gwr;
    logic [31:0] grd;
    e.tag = tag; e.rd = erd; e.wr = ewr; e.lat = elat;
    e.waits = (f3 == F3_RUN) ? elat - 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    pcpi_insn  = {17'd0, f3, 5'd0, OPC_CUSTOM0};
    pcpi_rs1   = a1;
    pcpi_rs2   = a2;
    pcpi_valid = 1'b1;
    n = 0; waits = 0; seen = 1'b0; grd = '0; gwr = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (pcpi_wait) waits++;
      if (pcpi_ready) begin
        seen = 1'b1; grd = pcpi_rd; gwr = pcpi_wr;
      end
    end
    extra = 0;
    repeat (hold) begin
      @(negedge clk);
      if (pcpi_ready) extra++;
    end
    pcpi_valid = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_ready"}, 32'(seen), 32'd1);
    chk({e.tag, "_lat"}, n, e.lat);
    chk({e.tag, "_rd"}, grd, e.rd);
    chk({e.tag, "_wr"}, 32'(gwr), 32'(e.wr));
    chk({e.tag, "_wait"}, waits, e.waits);
    if (hold > 0) chk({e.tag, "_dup"}, extra, 0);
  endtask

  task automatic wr_el(input logic [31:0] ix, input int v);
    logic signed [15:0] s;
    logic [31:0]        vv;
    vv = v;
    s  = vv[15:0];
    if (ix < NN) ma[ix] = s;
    else if (ix >= 32'h40 && ix < 32'h40 + NN) mb[ix-32'h40] = s;
    else if (ix >= 32'h80 && ix < 32'h80 + NN) mbias[ix-32'h80] = s;
    else if (ix == 32'hC0) mth = s;
    op(F3_WRITE, ix, vv, 32'd0, 1'b0, 1, 0, "wr");
  endtask

  task automatic run_chk(input string tag, input int hold);
    model_run();
    op(F3_RUN, 0, 0, model_mask(), 1'b1, 8, hold, tag);
  endtask

  task automatic rd_chk(input logic [31:0] ix, input string tag);
    logic [31:0] e;
    e = (ix < NN) ? sat32(mc[ix]) : 32'd0;
    op(F3_READ, ix, 0, e, 1'b1, 1, 0, tag);
  endtask

  initial begin
    int cr, cw;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_rd", pcpi_rd, 0);
    chk("rst_ctl", {29'd0, pcpi_ready, pcpi_wr, pcpi_wait}, 0);
    resetn = 1'b1;

    run_chk("run_zero", 0);

    wr_el(0, 1); wr_el(4, 1); wr_el(8, 1);
    for (int k = 0; k < NN; k++) wr_el(32'h40 + k, k + 1);
    run_chk("run_id", 0);
    rd_chk(4, "rd4");
    rd_chk(8, "rd8");

    wr_el(32'hC0, 5);
    run_chk("run_th5", 3);
    run_chk("run_th5_rep", 3);

    for (int k = 0; k < NN; k++) begin
      wr_el(k, -3);
      wr_el(32'h40 + k, 2);
    end
    wr_el(32'h80, 20);
    wr_el(32'hC0, -17);
    run_chk("run_neg", 0);
    rd_chk(0, "rd_c00");
    rd_chk(1, "rd_c01");

    wr_el(32'h09, 77);
    wr_el(32'hC1, 1000);
    wr_el(32'h100, 1000);
    run_chk("run_drop", 0);
    rd_chk(32'h50, "rd_oor");

    @(negedge clk);
    pcpi_insn  = {17'd0, 3'b011, 5'd0, OPC_CUSTOM0};
    pcpi_valid = 1'b1;
    cr = 0; cw = 0;
    repeat (10) begin
      @(negedge clk);
      if (pcpi_ready) cr++;
      if (pcpi_wait) cw++;
    end
    pcpi_valid = 1'b0;
    chk("f3_011_ready", cr, 0);
    chk("f3_011_wait", cw, 0);

    wr_el(32'hC0, 0);
    for (int k = 0; k < NN; k++) begin
      wr_el(k, -32768);
      wr_el(32'h40 + k, -32768);
    end
    run_chk("run_satp", 0);
    rd_chk(0, "rd_satp");
    for (int k = 0; k < NN; k++) wr_el(32'h40 + k, 32767);
    run_chk("run_satn", 0);
    rd_chk(4, "rd_satn");

    for (int k = 0; k < NN; k++) begin
      wr_el(k, int'($urandom_range(200)) - 100);
      wr_el(32'h40 + k, int'($urandom_range(200)) - 100);
      wr_el(32'h80 + k, int'($urandom_range(2000)) - 1000);
    end
    wr_el(32'hC0, int'($urandom_range(4000)) - 2000);
    run_chk("run_rand", 0);
    for (int k = 0; k < NN; k++) rd_chk(k, "rd_rand");

    op(F3_CLEAR, 0, 0, 32'd0, 1'b0, 1, 0, "clear");
    for (int k = 0; k < NN; k++) mc[k] = 0;
    rd_chk(4, "rd_clr");

    @(negedge clk);
    pcpi_insn  = {17'd0, F3_RUN, 5'd0, OPC_CUSTOM0};
    pcpi_valid = 1'b1;
    repeat (4) @(negedge clk);
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rd", pcpi_rd, 0);
    chk("abort_ctl", {29'd0, pcpi_ready, pcpi_wr, pcpi_wait}, 0);
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
    cr = 0;
    repeat (12) begin
      @(negedge clk);
      if (pcpi_ready) cr++;
    end
    chk("abort_noready", cr, 0);
    rd_chk(0, "rd_after_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
